aes_encrypt_arbiter: RTL and testbench
======================================

Name: aes_encrypt_arbiter

Overview:
Shares one AES encryption core between NUM_REQ independent requesters. Each requester submits a 128-bit plaintext and a 128-bit key over a valid/ready handshake. The block arbitrates round-robin, launches the core with a one-cycle start pulse, and waits for the core's finish flag or a timeout. It then returns the ciphertext to the granted requester over a valid/ready response handshake. It sits between client blocks and the encryption core, and is the core's only driver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 31, max cycles in WAIT before an error response (>=16)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_text  in  NUM_REQ*128  plaintexts; requester i at [128*i+:128]
req_key  in  NUM_REQ*128  keys; requester i at [128*i+:128]
rsp_valid  out  NUM_REQ  per-requester response valid, one-hot or zero
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_text  out  128  ciphertext, shared bus
rsp_error  out  1  1 = timeout, and rsp_text is 0
core_new_en  out  1  one-cycle start pulse to the core
core_plain_text  out  128  core plaintext
core_cipher_key  out  128  core key
core_cipher_text  in  128  core result
core_finish  in  1  core done, level
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current owner

Behaviour:
- Reset: clk is the only clock; reset_n is asynchronous and active-low.
  - State = IDLE, rr_ptr = 0, grant_id = 0.
  - All outputs are 0, including the core_* data registers and rsp_text.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[sel] = 1 combinationally in that same cycle.
  - Register req_text[sel], req_key[sel] into core_plain_text, core_cipher_key; register grant_id = sel.
  - Next state: LAUNCH.
  - No valid request: stay in IDLE, req_ready = 0.
- LAUNCH: core_new_en = 1 for exactly this cycle. Clear the timeout counter. Next state: WAIT.
- core_plain_text and core_cipher_key hold stable from LAUNCH until the block returns to IDLE.
- WAIT:
  - The counter increments every cycle.
  - core_finish is ignored on the first WAIT cycle (it may be a stale level from the previous operation).
  - From the second WAIT cycle on, the first cycle with core_finish = 1 does the following: capture rsp_text = core_cipher_text, set rsp_error = 0, go to RESP.
  - If the counter reaches TIMEOUT without a qualifying finish: rsp_text = 0, rsp_error = 1, go to RESP.
  - If finish and timeout occur in the same cycle, finish wins.
- RESP:
  - rsp_valid[grant_id] = 1; rsp_text and rsp_error are held stable.
  - The response completes on a cycle where rsp_ready[grant_id] = 1. On that cycle, rr_ptr = (grant_id+1) mod NUM_REQ and the next state is IDLE.
  - rsp_ready from other requesters is ignored.
  - No timeout applies in RESP; backpressure is unbounded.
- One request is in flight at a time. req_ready = 0 in every state except IDLE.
- Minimum request-to-next-accept latency is 5 cycles: accept, LAUNCH, WAIT x2, RESP with rsp_ready = 1.
- A requester may deassert req_valid before it is accepted; it is simply not selected.
- Data from a requester not yet accepted is never latched.
- Asserting reset_n low in any state aborts the current operation immediately:
  - No response is issued.
  - core_new_en goes to 0.
  - rr_ptr returns to 0.
- rsp_valid and req_ready are never set for an index >= NUM_REQ.

Test Plan:
- Single request on req 0, text 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, real core:
  - rsp_valid[0] goes high with rsp_text 69c4e0d86a7b0430d8cdb78070b4c55a and rsp_error 0.
  - core_new_en pulses exactly once.
- All 4 requesters valid continuously with rsp_ready all 1:
  - Grants go in order 0,1,2,3,0.
  - Each response matches a behavioural AES model for that requester's text/key.
- Requester 2 alone after a transaction for 3 completes:
  - rr_ptr = 0 after that transaction; req 2 is granted.
  - Then req 1 and req 3 valid together: req 3 is granted first (rr_ptr = 3).
- rsp_ready[1] held low for 20 cycles:
  - rsp_valid[1], rsp_text and busy are held.
  - No req_ready is asserted.
  - The grant proceeds the cycle after rsp_ready[1] rises.
- Stub core that never raises finish:
  - rsp_error = 1 and rsp_text = 0 after TIMEOUT WAIT cycles.
  - Stub finish held high from before launch: it is ignored on the first WAIT cycle and accepted on the second.
- reset_n pulsed low while in WAIT:
  - All outputs are 0 asynchronously and no rsp_valid appears.
  - A following request on req 1 completes normally.

Source files
------------

// File: rtl/aes_encrypt_arbiter_if.sv
// rtl/aes_encrypt_arbiter_if.sv - request/response and core-side bundle for the AES arbiter
interface aes_encrypt_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_text;
  logic [NUM_REQ*128-1:0] req_key;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [127:0]           rsp_text;
  logic                   rsp_error;
  logic                   core_new_en;
  logic [127:0]           core_plain_text;
  logic [127:0]           core_cipher_key;
  logic [127:0]           core_cipher_text;
  logic                   core_finish;

  // Requester side: issues requests, accepts responses
  modport master (
    output req_valid, req_text, req_key, rsp_ready,
    input  req_ready, rsp_valid, rsp_text, rsp_error
  );

  // Arbiter side: accepts requests, drives responses and the core
  modport slave (
    input  req_valid, req_text, req_key, rsp_ready,
    output req_ready, rsp_valid, rsp_text, rsp_error,
    output core_new_en, core_plain_text, core_cipher_key,
    input  core_cipher_text, core_finish
  );

  // Encryption core side
  modport core (
    input  core_new_en, core_plain_text, core_cipher_key,
    output core_cipher_text, core_finish
  );
endinterface

// File: rtl/aes_encrypt_arbiter.sv
// rtl/aes_encrypt_arbiter.sv - round-robin sharing of one AES core between NUM_REQ requesters
module aes_encrypt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                       clk,
  input  logic                       reset_n,
  aes_encrypt_arbiter_if.slave       bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] sel;
  logic           any_valid;
  logic [CW-1:0]  wait_cnt;

  // First valid requester at or after rr_ptr; the smallest offset wins
  always_comb begin
    sel       = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        sel       = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

  // Accept is combinational in IDLE and forced low while reset is held
  assign bus.req_ready = (reset_n && state == IDLE && any_valid) ? (NUM_REQ'(1) << sel) : '0;
  assign busy          = (state != IDLE);

  // Arbitration FSM with registered core and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      grant_id            <= '0;
      wait_cnt            <= '0;
      bus.core_new_en     <= 1'b0;
      bus.core_plain_text <= '0;
      bus.core_cipher_key <= '0;
      bus.rsp_valid       <= '0;
      bus.rsp_text        <= '0;
      bus.rsp_error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            bus.core_plain_text <= bus.req_text[128*int'(sel) +: 128];
            bus.core_cipher_key <= bus.req_key[128*int'(sel) +: 128];
            grant_id            <= sel;
            bus.core_new_en     <= 1'b1;
            state               <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.core_new_en <= 1'b0;
          wait_cnt        <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // wait_cnt == 0 marks the first WAIT cycle, where finish may be stale
          if (wait_cnt != '0 && bus.core_finish) begin
            bus.rsp_text  <= bus.core_cipher_text;
            bus.rsp_error <= 1'b0;
            bus.rsp_valid <= NUM_REQ'(1) << grant_id;
            state         <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            bus.rsp_text  <= '0;
            bus.rsp_error <= 1'b1;
            bus.rsp_valid <= NUM_REQ'(1) << grant_id;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant_id]) begin
            bus.rsp_valid <= '0;
            rr_ptr        <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_arbiter.sv
// tb/tb_aes_encrypt_arbiter.sv - scoreboard bench for aes_encrypt_arbiter with AES reference model
module tb_aes_encrypt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 31;
  localparam int IDW     = 2;
  localparam int M_NORM  = 0;
  localparam int M_STUCK = 1;
  localparam int M_TMO   = 2;
  localparam logic [127:0] KAT_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] STUCK_CT = 128'hfeedface_0badc0de_5a5a5a5a_13579bdf;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           busy;
  logic [IDW-1:0] grant_id;

  aes_encrypt_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  aes_encrypt_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES-128 reference model ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int j = 0; j < 16; j++) tmp[j] = sbox[st[j]];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) st[row+4*c] = tmp[row+4*((c+row)%4)];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
            st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) st[row+4*c] = st[row+4*c] ^ w[4*rnd+c][31-8*row -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
    return res;
  endfunction

  // ---------------- core stub ----------------
  int         core_mode = M_NORM;
  logic       stub_busy;
  int         stub_cnt;
  logic [127:0] stub_ct;

  // Behaves as the core: normal (finish after a random delay), stuck-high finish, or never finishing
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.core_finish      <= 1'b0;
      bus.core_cipher_text <= '0;
      stub_busy            <= 1'b0;
      stub_cnt             <= 0;
      stub_ct              <= '0;
    end else if (bus.core_new_en) begin
      if (core_mode == M_STUCK) begin
        bus.core_finish      <= 1'b1;
        bus.core_cipher_text <= STUCK_CT;
        stub_busy            <= 1'b0;
      end else begin
        bus.core_finish <= 1'b0;
        stub_busy       <= (core_mode == M_NORM);
        stub_cnt        <= int'($urandom_range(0, 6));
        stub_ct         <= aes128(bus.core_plain_text, bus.core_cipher_key);
      end
    end else if (core_mode == M_STUCK) begin
      bus.core_finish      <= 1'b1;
      bus.core_cipher_text <= STUCK_CT;
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        bus.core_finish      <= 1'b1;
        bus.core_cipher_text <= stub_ct;
        stub_busy            <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // ---------------- requester drivers ----------------
  logic [255:0]       pend [NUM_REQ][$];
  bit                 rand_valid = 1'b0;
  bit                 rand_rdy = 1'b0;
  logic [NUM_REQ-1:0] rdy_mask = '1;

  initial begin
    bus.req_valid = '0;
    bus.req_text  = '0;
    bus.req_key   = '0;
    bus.rsp_ready = '0;
  end

  // Present each requester's oldest pending item; junk data on the bus while not valid
  always @(posedge clk) begin
    logic v;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      v = (pend[i].size() > 0) && (!rand_valid || ($urandom_range(0, 2) != 0));
      bus.req_valid[i] = v;
      bus.req_text[128*i +: 128] = v ? pend[i][0][255:128] : {$urandom, $urandom, $urandom, $urandom};
      bus.req_key[128*i +: 128]  = v ? pend[i][0][127:0]   : {$urandom, $urandom, $urandom, $urandom};
    end
    bus.rsp_ready = rand_rdy ? NUM_REQ'($urandom) : rdy_mask;
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int           sel;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    logic         err;
    int           lat;
  } exp_t;

  exp_t         sb [$];
  int           m_rr = 0;
  bit           inflight = 1'b0;
  int           age = 0;
  int           nen = 0;
  bit           seen_rsp = 1'b0;
  int           grant_log [$];
  logic [127:0] last_rsp_text;

  always @(negedge clk) begin
    int                 s;
    int                 idx;
    logic [NUM_REQ-1:0] ev;
    exp_t               e;
    if (reset_n) begin
      s = -1;
      if (!inflight)
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (s < 0 && bus.req_valid[idx]) s = idx;
        end
      ev = (s >= 0) ? (NUM_REQ'(1) << s) : '0;
      check("req_ready", 256'(bus.req_ready), 256'(ev));
      check("busy", 256'(busy), 256'(inflight));
      if (bus.core_new_en) nen++;
      if (inflight) begin
        age++;
        check("grant_id", 256'(grant_id), 256'(sb[0].sel));
        check("core_operands", {bus.core_plain_text, bus.core_cipher_key}, {sb[0].pt, sb[0].key});
        if (bus.rsp_valid != '0) begin
          if (!seen_rsp && sb[0].lat > 0) check("rsp_latency", 256'(age), 256'(sb[0].lat));
          seen_rsp = 1'b1;
          check("rsp_valid", 256'(bus.rsp_valid), 256'(NUM_REQ'(1) << sb[0].sel));
          check("rsp_text", 256'(bus.rsp_text), 256'(sb[0].ct));
          check("rsp_error", 256'(bus.rsp_error), 256'(sb[0].err));
          if (bus.rsp_ready[sb[0].sel]) begin
            check("new_en_pulses", 256'(nen), 256'(1));
            last_rsp_text = bus.rsp_text;
            m_rr = (sb[0].sel + 1) % NUM_REQ;
            void'(sb.pop_front());
            inflight = 1'b0;
          end
        end else if (age > 200) begin
          check("rsp_never_arrived", 256'(0), 256'(1));
          void'(sb.pop_front());
          inflight = 1'b0;
        end
      end else begin
        check("rsp_valid_idle", 256'(bus.rsp_valid), 256'(0));
      end
      for (int k = 0; k < NUM_REQ; k++)
        if (bus.req_ready[k]) grant_log.push_back(k);
      if (s >= 0) begin
        e.sel = s;
        e.pt  = pend[s][0][255:128];
        e.key = pend[s][0][127:0];
        e.ct  = (core_mode == M_NORM) ? aes128(e.pt, e.key) : (core_mode == M_STUCK) ? STUCK_CT : '0;
        e.err = (core_mode == M_TMO);
        e.lat = (core_mode == M_STUCK) ? 4 : (core_mode == M_TMO) ? TIMEOUT + 2 : 0;
        sb.push_back(e);
        void'(pend[s].pop_front());
        inflight = 1'b1;
        age      = 0;
        nen      = 0;
        seen_rsp = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_core"}, {bus.core_plain_text, bus.core_cipher_key}, '0);
    check({tag, "_rsp"}, 256'({bus.rsp_text, bus.rsp_valid, bus.req_ready, bus.rsp_error,
                               bus.core_new_en, busy, grant_id}), '0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("reset_async");
    sb.delete();
    inflight = 1'b0;
    m_rr     = 0;
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit empty;
    for (int c = 0; c < max_cycles; c++) begin
      @(posedge clk);
      empty = !inflight;
      for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) empty = 1'b0;
      if (empty) return;
    end
    check("wait_idle_bound", 256'(0), 256'(1));
  endtask

  task automatic push_rand(input int r);
    pend[r].push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic check_grants(input string name, input int exp_g [], input int n);
    check({name, "_count"}, 256'(grant_log.size()), 256'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check(name, 256'(grant_log[i]), 256'(exp_g[i]));
  endtask

  initial begin
    int  exp_b [];
    int  exp_c [];
    bit  got;
    build_sbox();
    check("aes_model_kat", 256'(aes128(KAT_PT, KAT_KEY)), 256'(KAT_CT));
    #12 check_outputs_zero("reset_init");
    reset_n = 1'b1;

    // Known-answer request on requester 0
    pend[0].push_back({KAT_PT, KAT_KEY});
    wait_idle(200);
    check("kat_rsp_text", 256'(last_rsp_text), 256'(KAT_CT));

    // All four requesters contending, rr restarted at 0
    pulse_reset();
    grant_log.delete();
    for (int i = 0; i < NUM_REQ; i++) push_rand(i);
    push_rand(0);
    wait_idle(400);
    exp_b = new[5];
    exp_b = '{0, 1, 2, 3, 0};
    check_grants("grant_order_all", exp_b, 5);

    // 3 alone, then 2 alone, then 1 and 3 together
    grant_log.delete();
    push_rand(3);
    wait_idle(200);
    push_rand(2);
    wait_idle(200);
    push_rand(1);
    push_rand(3);
    wait_idle(400);
    exp_c = new[4];
    exp_c = '{3, 2, 3, 1};
    check_grants("grant_order_rr", exp_c, 4);

    // Response backpressure on requester 1, requester 0 queued behind it
    rdy_mask = 4'b1101;
    push_rand(1);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = bus.rsp_valid[1];
    end
    check("bp_rsp_seen", 256'(got), 256'(1));
    push_rand(0);
    repeat (20) @(posedge clk);
    rdy_mask = '1;
    wait_idle(200);

    // Core never finishes: timeout error response
    core_mode = M_TMO;
    push_rand(2);
    wait_idle(300);

    // Finish held high from before launch
    core_mode = M_STUCK;
    repeat (2) @(posedge clk);
    push_rand(0);
    wait_idle(200);
    core_mode = M_NORM;
    repeat (2) @(posedge clk);

    // Reset while in WAIT aborts, then a clean request on requester 1
    push_rand(0);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = bus.core_new_en;
    end
    check("abort_launch_seen", 256'(got), 256'(1));
    @(posedge clk);
    pulse_reset();
    push_rand(1);
    wait_idle(200);

    // Randomized traffic with valid withdrawal and random response backpressure
    rand_valid = 1'b1;
    rand_rdy   = 1'b1;
    for (int n = 0; n < 40; n++) begin
      push_rand(int'($urandom_range(0, NUM_REQ - 1)));
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    wait_idle(5000);
    rand_valid = 1'b0;
    rand_rdy   = 1'b0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
